// File: rtl/tdc_result_spi.sv
// TDC result SPI slave: captures {fine, coarse} on the falling edge of the TDC
// busy flag, tags it with a rolling sequence number and status flags, and
// presents it as a 48-bit mode-0 SPI frame clocked by an asynchronous master.
// A capture that lands while a frame is being shifted is parked in a pending
// register and promoted to the holding register when chip select rises.
module tdc_result_spi #(
    parameter int FRAME_W = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tdc_busy,
    input  logic [31:0] coarse_result,
    input  logic [8:0]  fine_result,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        data_ready,
    output logic        overrun
);

    // Stored record: seq, fine, coarse (flags are added when the frame is built).
    localparam int REC_W = FRAME_W - 2;
    localparam logic [5:0] FULL_CNT = 6'(FRAME_W);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    // Synchronizer stages: _p0/_p1 resolve metastability, _p2 is edge history.
    logic busy_p0, busy_p1, busy_p2;
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0,   cs_p1,   cs_p2;

    logic busy_fall, sclk_rise, sclk_fall, cs_fall, cs_rise;

    state_t             state, state_n;
    logic [4:0]         seq, seq_n;
    logic [REC_W-1:0]   hold, hold_n;
    logic [REC_W-1:0]   pend, pend_n;
    logic               pend_valid, pend_valid_n;
    logic               data_ready_n, overrun_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [5:0]         bit_cnt, bit_cnt_n;
    logic               miso_n;
    logic [REC_W-1:0]   cap_rec;
    logic               cap_to_pend;
    logic               xfer_end;

    // Bring the three asynchronous pins into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_p0 <= 1'b0;
            busy_p1 <= 1'b0;
            busy_p2 <= 1'b0;
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
        end else begin
            busy_p0 <= tdc_busy;
            busy_p1 <= busy_p0;
            busy_p2 <= busy_p1;
            sclk_p0 <= spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi_cs_n;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
        end
    end

    assign busy_fall = busy_p2 & ~busy_p1;
    assign sclk_rise = ~sclk_p2 & sclk_p1;
    assign sclk_fall = sclk_p2 & ~sclk_p1;
    assign cs_fall   = cs_p2 & ~cs_p1;
    assign cs_rise   = ~cs_p2 & cs_p1;

    // The record carries the post-increment sequence number.
    assign cap_rec = {seq + 5'd1, fine_result, coarse_result};

    // Next-state logic; flag updates are ordered completion clear, then
    // pending promotion, then new capture, so same-cycle events compose.
    always_comb begin
        state_n      = state;
        seq_n        = seq;
        hold_n       = hold;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        data_ready_n = data_ready;
        overrun_n    = overrun;
        shreg_n      = shreg;
        bit_cnt_n    = bit_cnt;
        xfer_end     = (state == XFER) && cs_rise;
        cap_to_pend  = ((state == XFER) && !cs_rise) || ((state == IDLE) && cs_fall);

        if (xfer_end && (bit_cnt == FULL_CNT)) begin
            data_ready_n = 1'b0;
            overrun_n    = 1'b0;
        end

        if (xfer_end && pend_valid) begin
            hold_n = pend;
            if (data_ready_n) begin
                overrun_n = 1'b1;
            end
            data_ready_n = 1'b1;
            pend_valid_n = 1'b0;
        end

        if (busy_fall) begin
            seq_n = seq + 5'd1;
            if (cap_to_pend) begin
                if (pend_valid_n) begin
                    overrun_n = 1'b1;
                end
                pend_n       = cap_rec;
                pend_valid_n = 1'b1;
            end else begin
                if (data_ready_n) begin
                    overrun_n = 1'b1;
                end
                hold_n       = cap_rec;
                data_ready_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n   = XFER;
                    shreg_n   = {data_ready, overrun, hold};
                    bit_cnt_n = 6'd0;
                end
            end
            XFER: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    shreg_n = '0;
                end else begin
                    if (sclk_rise && (bit_cnt < FULL_CNT)) begin
                        bit_cnt_n = bit_cnt + 6'd1;
                    end
                    if (sclk_fall) begin
                        shreg_n = {shreg[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        miso_n = (state_n == XFER) ? shreg_n[FRAME_W-1] : 1'b0;
    end

    // Register FSM state, datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            seq        <= 5'd0;
            hold       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= 6'd0;
            spi_miso   <= 1'b0;
        end else begin
            state      <= state_n;
            seq        <= seq_n;
            hold       <= hold_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            data_ready <= data_ready_n;
            overrun    <= overrun_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            spi_miso   <= miso_n;
        end
    end

endmodule
